psram_qpi_ctrl: RTL

PSRAM_QPI_CTRL -- requirements
Module: psram_qpi_ctrl

---
 rtl/psram_qpi_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/psram_qpi_ctrl.sv
// psram_qpi_ctrl
// Burst read/write controller for CHIPS parallel x4 PSRAM devices in QPI mode.
// After power-up it waits RESET_WAIT cycles, sends the 0x35 "enter QPI"
// command serially on IO0, then serves word-wide burst requests.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_stb               request strobe (only looked at in IDLE)
//   i_we                1 = write, 0 = read
//   i_addr[23:0]        start address in words
//   i_len[5:0]          word count (0 -> 1 word, clipped to BURST_MAX)
//   i_din[W-1:0]        write word, sampled the cycle after o_din_req
//   o_din_req           one-cycle pulse asking for the next write word
//   o_dout, o_dout_vld  read word and its one-cycle valid pulse
//   o_busy              high in every state except IDLE
//   o_done              one-cycle completion pulse (also on rejection)
//   o_err               one-cycle pulse when a request would cross a 1 KiW page
//   o_psram_*           device bus: csn, sclk, data out, output enable, data in
//   o_state, o_states_hit  (PSRAM_DEBUG_EN only) FSM encoding and sticky
//                       per-state visit bits
//
// Handshake: a request is taken on any cycle with i_stb=1 and o_busy=0;
// the caller must then supply one i_din per o_din_req pulse (write) or accept
// one o_dout per o_dout_vld pulse (read); there is no back-pressure.
//
// Build option: define PSRAM_DEBUG_EN to add the debug ports.
module psram_qpi_ctrl #(
  parameter int CHIPS      = 2,
  parameter int BURST_MAX  = 8,
  parameter int WAIT_SLOTS = 7,
  parameter int RESET_WAIT = 20000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_stb,
  input  logic                 i_we,
  input  logic [23:0]          i_addr,
  input  logic [5:0]           i_len,
  input  logic [8*CHIPS-1:0]   i_din,
  output logic                 o_din_req,
  output logic [8*CHIPS-1:0]   o_dout,
  output logic                 o_dout_vld,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_psram_csn,
  output logic                 o_psram_sclk,
  output logic [4*CHIPS-1:0]   o_psram_dout,
  output logic                 o_psram_oe,
  input  logic [4*CHIPS-1:0]   i_psram_din
`ifdef PSRAM_DEBUG_EN
  ,
  output logic [3:0]           o_state,
  output logic [8:0]           o_states_hit
`endif
);

  localparam int BW  = 4 * CHIPS;
  localparam int WW  = 8 * CHIPS;
  localparam int CW0 = $clog2(RESET_WAIT + 1);
  localparam int CW  = (CW0 < 5) ? 5 : CW0;

  typedef enum logic [3:0] {
    INIT_WAIT = 4'd0,
    INIT_CMD  = 4'd1,
    IDLE      = 4'd2,
    CMD       = 4'd3,
    ADDR      = 4'd4,
    DUMMY     = 4'd5,
    RDATA     = 4'd6,
    WDATA     = 4'd7,
    DESEL     = 4'd8
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_tx;      // outgoing command/address bits, MSB first
  logic            r_we;
  logic [5:0]      r_len;
  logic [5:0]      r_words;
  logic            r_nib;     // 0 = upper-half slot of a word, 1 = lower-half
  logic [BW-1:0]   r_wlo;     // lower half of the write word in flight
  logic [BW-1:0]   r_rhi;     // upper half of the read word in flight
  logic            r_report;  // 0 while finishing INIT: DESEL gives no done
  logic            r_csn;
  logic            r_sclk;
  logic            r_oe;
  logic [BW-1:0]   r_pdout;
  logic [WW-1:0]   r_dout;
  logic            r_dout_vld;
  logic            r_din_req;
  logic            r_done;
  logic            r_err;

  logic [5:0]      w_len;
  logic            w_cross;
  logic [7:0]      w_cmd;

  function automatic logic [BW-1:0] rep_nib(input logic [3:0] n);
    logic [BW-1:0] r;
    r = '0;
    for (int k = 0; k < CHIPS; k++) r[4*k +: 4] = n;
    return r;
  endfunction

  always_comb begin
    w_len = i_len;
    if (i_len == 6'd0)
      w_len = 6'd1;
    else if (i_len > 6'(BURST_MAX))
      w_len = 6'(BURST_MAX);
    w_cross = ({1'b0, i_addr[9:0]} + {5'b0, w_len}) > 11'd1024;
    w_cmd   = i_we ? 8'h38 : 8'hEB;
  end

  // SCLK toggles every cycle while selected: each slot is one low cycle
  // (new data on the bus) followed by one high cycle (device samples).
  // Slot bookkeeping therefore happens only in the r_sclk=1 cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= INIT_WAIT;
      r_cnt      <= '0;
      r_tx       <= '0;
      r_we       <= 1'b0;
      r_len      <= '0;
      r_words    <= '0;
      r_nib      <= 1'b0;
      r_wlo      <= '0;
      r_rhi      <= '0;
      r_report   <= 1'b0;
      r_csn      <= 1'b1;
      r_sclk     <= 1'b0;
      r_oe       <= 1'b0;
      r_pdout    <= '0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_din_req  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_din_req  <= 1'b0;
      r_dout_vld <= 1'b0;
      r_sclk     <= r_csn ? 1'b0 : ~r_sclk;

      case (r_state)
        INIT_WAIT: begin
          if (r_cnt == CW'(RESET_WAIT - 1)) begin
            r_state <= INIT_CMD;
            r_csn   <= 1'b0;
            r_oe    <= 1'b1;
            r_pdout <= rep_nib(4'h0);              // bit 7 of 0x35
            r_tx    <= {7'b0110101, 25'b0};        // bits 6..0 of 0x35
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        INIT_CMD: begin
          if (r_sclk) begin
            if (r_cnt == CW'(7)) begin
              r_state <= DESEL;
              r_csn   <= 1'b1;
              r_sclk  <= 1'b0;
              r_oe    <= 1'b0;
              r_pdout <= '0;
              r_cnt   <= '0;
            end else begin
              r_pdout <= rep_nib({3'b000, r_tx[31]});
              r_tx    <= {r_tx[30:0], 1'b0};
              r_cnt   <= r_cnt + CW'(1);
            end
          end
        end

        IDLE: begin
          if (i_stb) begin
            if (w_cross) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_state  <= CMD;
              r_csn    <= 1'b0;
              r_oe     <= 1'b1;
              r_we     <= i_we;
              r_len    <= w_len;
              r_words  <= '0;
              r_nib    <= 1'b0;
              r_report <= 1'b1;
              r_pdout  <= rep_nib(w_cmd[7:4]);
              r_tx     <= {w_cmd[3:0], i_addr, 4'h0};
              r_cnt    <= '0;
            end
          end
        end

        CMD: begin
          if (r_sclk) begin
            r_pdout <= rep_nib(r_tx[31:28]);
            r_tx    <= {r_tx[27:0], 4'h0};
            if (r_cnt == CW'(1)) begin
              r_state <= ADDR;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end

        ADDR: begin
          if (r_sclk) begin
            if (r_cnt == CW'(5)) begin
              r_cnt <= '0;
              r_nib <= 1'b0;
              if (r_we) begin
                r_state <= WDATA;
                r_pdout <= i_din[WW-1:BW];
                r_wlo   <= i_din[BW-1:0];
              end else begin
                r_state <= DUMMY;
                r_oe    <= 1'b0;
                r_pdout <= '0;
              end
            end else begin
              r_pdout <= rep_nib(r_tx[31:28]);
              r_tx    <= {r_tx[27:0], 4'h0};
              r_cnt   <= r_cnt + CW'(1);
              // Request lands two cycles before the first data slot.
              if (r_cnt == CW'(4) && r_we) r_din_req <= 1'b1;
            end
          end
        end

        WDATA: begin
          if (r_sclk) begin
            if (!r_nib) begin
              r_pdout <= r_wlo;
              r_nib   <= 1'b1;
              r_words <= r_words + 6'd1;
              if (r_words + 6'd1 < r_len) r_din_req <= 1'b1;
            end else if (r_words == r_len) begin
              r_state <= DESEL;
              r_csn   <= 1'b1;
              r_sclk  <= 1'b0;
              r_oe    <= 1'b0;
              r_pdout <= '0;
              r_cnt   <= '0;
            end else begin
              r_pdout <= i_din[WW-1:BW];
              r_wlo   <= i_din[BW-1:0];
              r_nib   <= 1'b0;
            end
          end
        end

        DUMMY: begin
          if (r_sclk) begin
            if (r_cnt == CW'(WAIT_SLOTS - 1)) begin
              r_state <= RDATA;
              r_cnt   <= '0;
              r_nib   <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end

        RDATA: begin
          if (r_sclk) begin
            if (!r_nib) begin
              r_rhi <= i_psram_din;
              r_nib <= 1'b1;
            end else begin
              r_dout     <= {r_rhi, i_psram_din};
              r_dout_vld <= 1'b1;
              r_nib      <= 1'b0;
              if (r_words + 6'd1 == r_len) begin
                r_state <= DESEL;
                r_csn   <= 1'b1;
                r_sclk  <= 1'b0;
                r_pdout <= '0;
                r_cnt   <= '0;
              end else begin
                r_words <= r_words + 6'd1;
              end
            end
          end
        end

        DESEL: begin
          // Two cycles here plus at least one in IDLE keep csn high >= 2 cycles.
          if (r_cnt == CW'(1)) begin
            r_state <= IDLE;
            r_done  <= r_report;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        default: begin
          r_state <= INIT_WAIT;
          r_cnt   <= '0;
          r_csn   <= 1'b1;
          r_oe    <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy       = (r_state != IDLE);
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_din_req    = r_din_req;
  assign o_dout       = r_dout;
  assign o_dout_vld   = r_dout_vld;
  assign o_psram_csn  = r_csn;
  assign o_psram_sclk = r_sclk;
  assign o_psram_dout = r_pdout;
  assign o_psram_oe   = r_oe;

`ifdef PSRAM_DEBUG_EN
  logic [8:0] r_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_hit <= '0;
    else       r_hit <= r_hit | (9'd1 << r_state);
  end

  assign o_state      = r_state;
  assign o_states_hit = r_hit;
`endif

endmodule
